// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the controller state enum, bubble-count limits and register width.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam int LU_MIN = 1;
  localparam int LU_MAX = 3;
  localparam int REG_AW = 5;

  // Keeps an out-of-range bubble request inside the supported window.
  function automatic int lu_clamp(input int n);
    if (n < LU_MIN) return LU_MIN;
    if (n > LU_MAX) return LU_MAX;
    return n;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_cmp.sv
// load_use_cmp: combinational load-use hit detector.
// In: EX load flag/rd, ID rs1/rs2 and use flags. Out: luHit_o.
module load_use_cmp
  import pipeline_ctrl_pkg::*;
(
  input  logic              ex_memRead_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  output logic              luHit_o
);

  logic rdValid;
  logic rs1Hit;
  logic rs2Hit;

  // x0 is hardwired zero, so a load to it never creates a dependency.
  assign rdValid = ex_memRead_i & (ex_rd_i != '0);
  assign rs1Hit  = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2Hit  = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign luHit_o = rdValid & (rs1Hit | rs2Hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// In: clk_i, rst_i (sync, active-high), ID source regs/use flags, EX load
//   info, branchTaken_i, dmem_req_i/dmem_ack_i.
// Out: stall_o, hazardDetected_o, IFFlush_o, pcWrite_o, idexBubble_o,
//   stallCycles_o and flushCount_o (saturating statistics).
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_memRead_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branchTaken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              stall_o,
  output logic              hazardDetected_o,
  output logic              IFFlush_o,
  output logic              pcWrite_o,
  output logic              idexBubble_o,
  output logic [CNT_W-1:0]  stallCycles_o,
  output logic [CNT_W-1:0]  flushCount_o
);

  localparam int         LU_N      = lu_clamp(LU_BUBBLES);
  localparam logic [1:0] LU_RELOAD = 2'(LU_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [1:0]       luCnt_q, luCnt_d;
  logic             flushPending_q, flushPending_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic luHit;
  logic memWait;
  logic flushWant;

  load_use_cmp u_lu_cmp (
    .ex_memRead_i  (ex_memRead_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .luHit_o       (luHit)
  );

  // Ack in the request cycle is a zero-wait access.
  assign memWait   = dmem_req_i & ~dmem_ack_i;
  assign flushWant = branchTaken_i | flushPending_q;

  always_comb begin
    state_d          = state_q;
    luCnt_d          = luCnt_q;
    stall_o          = 1'b0;
    hazardDetected_o = 1'b0;
    IFFlush_o        = 1'b0;
    idexBubble_o     = 1'b0;
    pcWrite_o        = 1'b1;

    unique case (state_q)
      RUN: begin
        if (memWait) begin
          stall_o   = 1'b1;
          pcWrite_o = 1'b0;
          state_d   = MEM_WAIT;
        end else if (luHit) begin
          hazardDetected_o = 1'b1;
          idexBubble_o     = 1'b1;
          pcWrite_o        = 1'b0;
          if (LU_N > 1) begin
            state_d = LU_WAIT;
            luCnt_d = LU_RELOAD;
          end
        end else if (flushWant) begin
          IFFlush_o = 1'b1;
        end
      end

      LU_WAIT: begin
        // A memory wait freezes everything; the owed bubbles resume later.
        if (memWait) begin
          stall_o   = 1'b1;
          pcWrite_o = 1'b0;
          state_d   = MEM_WAIT;
        end else begin
          hazardDetected_o = 1'b1;
          idexBubble_o     = 1'b1;
          pcWrite_o        = 1'b0;
          luCnt_d          = luCnt_q - 2'd1;
          if (luCnt_q <= 2'd1) begin
            state_d = RUN;
            luCnt_d = 2'd0;
          end
        end
      end

      MEM_WAIT: begin
        stall_o   = ~dmem_ack_i;
        pcWrite_o = dmem_ack_i;
        if (dmem_ack_i) begin
          state_d = (luCnt_q != 2'd0) ? LU_WAIT : RUN;
        end
      end

      default: begin
        state_d = RUN;
        luCnt_d = 2'd0;
      end
    endcase

    if (rst_i) begin
      stall_o          = 1'b0;
      hazardDetected_o = 1'b0;
      IFFlush_o        = 1'b0;
      idexBubble_o     = 1'b0;
      pcWrite_o        = 1'b1;
    end
  end

  // A branch that cannot flush now (stall, bubble or ack cycle) is held
  // until the first cycle IF/ID will accept the clear.
  assign flushPending_d = flushWant & ~IFFlush_o;

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if ((stall_o | hazardDetected_o) && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
    if (IFFlush_o && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      luCnt_q        <= 2'd0;
      flushPending_q <= 1'b0;
      stallCnt_q     <= '0;
      flushCnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      luCnt_q        <= luCnt_d;
      flushPending_q <= flushPending_d;
      stallCnt_q     <= stallCnt_d;
      flushCnt_q     <= flushCnt_d;
    end
  end

  assign stallCycles_o = stallCnt_q;
  assign flushCount_o  = flushCnt_q;

endmodule
